// File: rtl/mips_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_cpu_bus_arbiter
//
// Shares the CPU's single Avalon-MM master port between the instruction-fetch
// requester and the data load/store requester. Each transaction runs through
// IDLE (arbitrate and latch the winner's fields), BUS (drive the Avalon
// strobes until waitrequest drops) and RESP (one-cycle acknowledge, with read
// data captured into a hold register). Stall cycles are counted with a
// saturating counter.
//
// Parameters:
//   DATA_FIRST   - fixed-priority winner when both requesters are pending
//                  (1 = data, 0 = fetch); not used when round-robin is built
//   STALL_CNT_W  - width of the saturating stall counter
//
// Compile-time option:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are granted to
//                        the requester that was not granted last
//
// Ports:
//   clk, reset           clock (posedge) and synchronous active-low reset
//   fetch_req/addr       fetch request and instruction address
//   fetch_ack/rdata      one-cycle done pulse and fetched word (held after)
//   data_req/we/addr/    data request, write flag, address, store data and
//   data_wdata/be        byte enables
//   data_ack/rdata       one-cycle done pulse and load word (held after)
//   address/read/write/  Avalon master outputs
//   writedata/byteenable
//   waitrequest/readdata Avalon slave responses
//   stall_count          saturating count of stalled strobe cycles
// -----------------------------------------------------------------------------
module mips_cpu_bus_arbiter #(
   parameter bit DATA_FIRST  = 1'b1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_req,
   input  logic [31:0]            fetch_addr,
   output logic                   fetch_ack,
   output logic [31:0]            fetch_rdata,
   input  logic                   data_req,
   input  logic                   data_we,
   input  logic [31:0]            data_addr,
   input  logic [31:0]            data_wdata,
   input  logic [3:0]             data_be,
   output logic                   data_ack,
   output logic [31:0]            data_rdata,
   output logic [31:0]            address,
   output logic                   read,
   output logic                   write,
   input  logic                   waitrequest,
   output logic [31:0]            writedata,
   output logic [3:0]             byteenable,
   input  logic [31:0]            readdata,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t state_r;
   state_t state_nxt_s;

   logic any_req_s;
   logic grant_data_s;
   logic zero_be_wr_s;

   logic gnt_data_r;    // 1 = current transaction belongs to data side
   logic is_write_r;
   logic no_strobe_r;   // zero-byte store: no Avalon cycle is issued
   logic read_r;
   logic write_r;
   logic fetch_ack_r;
   logic data_ack_r;
   logic [31:0] address_r;
   logic [31:0] writedata_r;
   logic [3:0]  byteenable_r;
   logic [31:0] fetch_hold_r;
   logic [31:0] data_hold_r;
   logic [STALL_CNT_W-1:0] stall_cnt_r;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_data_r;   // 1 = last grant went to data, 0 = to fetch
`endif

   assign any_req_s    = fetch_req | data_req;
   assign zero_be_wr_s = data_we & (data_be == 4'b0000);

   // Arbitration: pick the winner among pending requesters.
   always_comb begin
      grant_data_s = 1'b0;
      if (data_req && fetch_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant_data_s = ~last_data_r;
`else
         grant_data_s = DATA_FIRST;
`endif
      end else if (data_req) begin
         grant_data_s = 1'b1;
      end else begin
         grant_data_s = 1'b0;
      end
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_nxt_s = BUS;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUS: begin
            // A zero-byte store spends the bus slot without strobes, so the
            // acknowledge keeps the same two-cycle latency as a real access.
            if (no_strobe_r || !waitrequest) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = BUS;
            end
         end
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Round-robin pointer: remembers which side won the most recent grant.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_data_r <= 1'b0;
      end else if (state_r == IDLE && any_req_s) begin
         last_data_r <= grant_data_s;
      end
   end
`endif

   // Transaction datapath: latch fields, drive strobes, generate acks,
   // capture read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         gnt_data_r   <= 1'b0;
         is_write_r   <= 1'b0;
         no_strobe_r  <= 1'b0;
         read_r       <= 1'b0;
         write_r      <= 1'b0;
         fetch_ack_r  <= 1'b0;
         data_ack_r   <= 1'b0;
         address_r    <= 32'h0000_0000;
         writedata_r  <= 32'h0000_0000;
         byteenable_r <= 4'b0000;
         fetch_hold_r <= 32'h0000_0000;
         data_hold_r  <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  gnt_data_r <= grant_data_s;
                  if (grant_data_s) begin
                     is_write_r  <= data_we;
                     no_strobe_r <= zero_be_wr_s;
                     read_r      <= ~data_we;
                     write_r     <= data_we & ~zero_be_wr_s;
                     // The bus fields are left untouched when no cycle is issued.
                     if (!zero_be_wr_s) begin
                        address_r    <= data_addr & 32'hFFFF_FFFC;
                        writedata_r  <= data_wdata;
                        byteenable_r <= data_be;
                     end
                  end else begin
                     is_write_r   <= 1'b0;
                     no_strobe_r  <= 1'b0;
                     read_r       <= 1'b1;
                     write_r      <= 1'b0;
                     address_r    <= fetch_addr & 32'hFFFF_FFFC;
                     byteenable_r <= 4'b1111;
                  end
               end
            end
            BUS: begin
               if (no_strobe_r || !waitrequest) begin
                  read_r      <= 1'b0;
                  write_r     <= 1'b0;
                  fetch_ack_r <= ~gnt_data_r;
                  data_ack_r  <= gnt_data_r;
               end
            end
            RESP: begin
               fetch_ack_r <= 1'b0;
               data_ack_r  <= 1'b0;
               if (!is_write_r) begin
                  if (gnt_data_r) begin
                     data_hold_r <= readdata;
                  end else begin
                     fetch_hold_r <= readdata;
                  end
               end
            end
            default: begin
               read_r      <= 1'b0;
               write_r     <= 1'b0;
               fetch_ack_r <= 1'b0;
               data_ack_r  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating stall counter: counts strobe cycles held off by waitrequest.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_r <= {STALL_CNT_W{1'b0}};
      end else if ((read_r || write_r) && waitrequest &&
                   (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign fetch_ack   = fetch_ack_r;
   assign data_ack    = data_ack_r;
   assign read        = read_r;
   assign write       = write_r;
   assign address     = address_r;
   assign writedata   = writedata_r;
   assign byteenable  = byteenable_r;
   assign stall_count = stall_cnt_r;

   // During the ack cycle of a read the word is passed straight through from
   // the bus; afterwards the captured copy is shown.
   assign fetch_rdata = fetch_ack_r ? readdata : fetch_hold_r;
   assign data_rdata  = (data_ack_r && !is_write_r) ? readdata : data_hold_r;

endmodule
